// File: rtl/wb_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_pipe
//  Description : DLX write-back stage. Holds the MEM/WB pipeline register and
//                selects ALU result, aligned/extended load data or link value.
//                The registered result drives the register-file write port and
//                a forwarding tap. Stall holds the register; flush squashes it.
//  Ports       : clk, reset (async, active-high)
//                in_*      - instruction presented by the MEM stage
//                in_ready  - stage accepts input this cycle (= !stall)
//                stall/flush - hazard-unit controls
//                rf_*      - register-file write port
//                fwd_*     - forwarding tap (pending write to rd != 0)
//                retire_cnt - number of committed register-file writes
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CNT_W = 32,
    localparam int AW   = $clog2(XLEN / 8)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_result,
    input  logic [XLEN-1:0]  in_rdata,
    input  logic [XLEN-1:0]  in_link,
    input  logic [1:0]       in_wsel,
    input  logic [1:0]       in_ldsize,
    input  logic             in_ldsigned,
    input  logic [AW-1:0]    in_addr_lo,
    input  logic [RADDR-1:0] in_rd,
    input  logic             in_regwrite,
    input  logic             stall,
    input  logic             flush,
    output logic             rf_we,
    output logic [RADDR-1:0] rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             fwd_valid,
    output logic [RADDR-1:0] fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int NLANES = XLEN / 8;

    // ------------------------------------------------------------------
    // Byte lanes, big-endian: lane 0 is the most significant byte.
    // ------------------------------------------------------------------
    logic [7:0] lane_w [NLANES];

    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
        assign lane_w[gi] = in_rdata[XLEN-1-8*gi -: 8];
    end

    logic [AW-1:0]   hidx_hi_w;
    logic [AW-1:0]   hidx_lo_w;
    logic [7:0]      byte_w;
    logic [15:0]     half_w;
    logic [XLEN-1:0] load_w;
    logic [XLEN-1:0] sel_w;

    // Halfword k occupies lanes {2k, 2k+1}; address bit 0 is ignored.
    assign hidx_hi_w = in_addr_lo & ~AW'(1);
    assign hidx_lo_w = in_addr_lo |  AW'(1);
    assign byte_w    = lane_w[in_addr_lo];
    assign half_w    = {lane_w[hidx_hi_w], lane_w[hidx_lo_w]};

    always_comb begin
        load_w = in_rdata;
        case (in_ldsize)
            2'b01:   load_w = {{(XLEN-16){in_ldsigned & half_w[15]}}, half_w};
            2'b10:   load_w = {{(XLEN-8){in_ldsigned & byte_w[7]}}, byte_w};
            default: load_w = in_rdata;
        endcase
    end

    always_comb begin
        sel_w = in_result;
        case (in_wsel)
            2'b01:   sel_w = load_w;
            2'b10:   sel_w = in_link;
            default: sel_w = in_result;
        endcase
    end

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    logic             valid_q,    valid_d;
    logic             regwrite_q, regwrite_d;
    logic [RADDR-1:0] rd_q,       rd_d;
    logic [XLEN-1:0]  data_q,     data_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             pending_w;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        data_d     = data_q;
        if (flush) begin
            // Flush wins over stall: the held instruction is dropped.
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d    = in_valid;
            regwrite_d = in_regwrite;
            rd_d       = in_rd;
            data_d     = sel_w;
        end
    end

    // A pending write is visible to forwarding even while stalled; the
    // register-file write itself fires only on the release cycle so it
    // happens exactly once per instruction.
    assign pending_w = valid_q & regwrite_q & (rd_q != '0);
    assign rf_we     = pending_w & ~stall;

    assign cnt_d = cnt_q + CNT_W'(rf_we);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = ~stall;
    assign rf_waddr   = rd_q;
    assign rf_wdata   = data_q;
    assign fwd_valid  = pending_w;
    assign fwd_rd     = rd_q;
    assign fwd_data   = data_q;
    assign retire_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage_pipe
//  Description : Self-checking bench for wb_stage_pipe. Expected writes are
//                queued when stimulus is driven and popped when rf_we fires.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_stage_pipe;

    localparam int XLEN  = 32;
    localparam int RADDR = 5;
    localparam int CNT_W = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_result;
    logic [XLEN-1:0]  in_rdata;
    logic [XLEN-1:0]  in_link;
    logic [1:0]       in_wsel;
    logic [1:0]       in_ldsize;
    logic             in_ldsigned;
    logic [AW-1:0]    in_addr_lo;
    logic [RADDR-1:0] in_rd;
    logic             in_regwrite;
    logic             stall;
    logic             flush;
    logic             rf_we;
    logic [RADDR-1:0] rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             fwd_valid;
    logic [RADDR-1:0] fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic [CNT_W-1:0] retire_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [RADDR-1:0] addr;
        logic [XLEN-1:0]  data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    wb_stage_pipe #(.XLEN(XLEN), .RADDR(RADDR), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_rdata(in_rdata), .in_link(in_link),
        .in_wsel(in_wsel), .in_ldsize(in_ldsize), .in_ldsigned(in_ldsigned),
        .in_addr_lo(in_addr_lo), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .stall(stall), .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retire_cnt(retire_cnt)
    );

    // Write monitor: samples 3 ns after the falling edge, 2 ns before the
    // rising edge that commits the write.
    always @(negedge clk) begin
        #3;
        if (reset === 1'b0 && rf_we === 1'b1) begin
            wr_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
                    n_fails++;
                    $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             rf_waddr, rf_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_result   = '0;
        in_rdata    = '0;
        in_link     = '0;
        in_wsel     = 2'b00;
        in_ldsize   = 2'b00;
        in_ldsigned = 1'b0;
        in_addr_lo  = '0;
        in_rd       = '0;
        in_regwrite = 1'b0;
    endtask

    // Drive one instruction at the falling edge; push its expected write.
    task automatic drive(input logic [1:0] wsel, input logic [XLEN-1:0] res,
                         input logic [XLEN-1:0] rdat, input logic [XLEN-1:0] lnk,
                         input logic [1:0] lsz, input logic lsg, input logic [AW-1:0] alo,
                         input logic [RADDR-1:0] rd, input logic rw,
                         input logic [XLEN-1:0] exp_data, input logic push);
        wr_t e;
        @(negedge clk);
        in_valid = 1'b1; in_wsel = wsel; in_result = res; in_rdata = rdat;
        in_link = lnk; in_ldsize = lsz; in_ldsigned = lsg; in_addr_lo = alo;
        in_rd = rd; in_regwrite = rw;
        if (push) begin
            e.addr = rd; e.data = exp_data;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle_inputs();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk); #3;
        n_checks++;
        if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin
            n_fails++; $display("FAIL reset_we: got we=%b fwd=%b, required 0 0", rf_we, fwd_valid);
        end
        n_checks++;
        if (rf_waddr !== '0 || rf_wdata !== '0 || fwd_rd !== '0 || fwd_data !== '0) begin
            n_fails++; $display("FAIL reset_data: got addr=%0d data=%h, required 0 0", rf_waddr, rf_wdata);
        end
        n_checks++;
        if (retire_cnt !== '0 || in_ready !== 1'b1) begin
            n_fails++; $display("FAIL reset_cnt: got cnt=%0d ready=%b, required 0 1", retire_cnt, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_result();
        drive(2'b00, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b0, 2'd0, 5'd7, 1'b1, 32'h1234_5678, 1'b1);
        drive(2'b11, 32'hCAFE_0001, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0, 5'd3, 1'b1, 32'hCAFE_0001, 1'b1);
        drive(2'b01, 32'h0, 32'hA5A5_5A5A, 32'h0, 2'b00, 1'b1, 2'd2, 5'd4, 1'b1, 32'hA5A5_5A5A, 1'b1);
        drive(2'b01, 32'h0, 32'h8765_4321, 32'h0, 2'b11, 1'b1, 2'd1, 5'd5, 1'b1, 32'h8765_4321, 1'b1);
        idle_cycles(3);
        #3;
        n_checks++;
        if (retire_cnt !== 4'd4) begin
            n_fails++; $display("FAIL result_cnt: got %0d, required 4", retire_cnt);
        end
    endtask

    task automatic test_load_align();
        drive(2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 2'b10, 1'b1, 2'd0, 5'd10, 1'b1, 32'hFFFF_FF80, 1'b1);
        drive(2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 2'b10, 1'b0, 2'd3, 5'd11, 1'b1, 32'h0000_0001, 1'b1);
        drive(2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 2'b10, 1'b1, 2'd1, 5'd12, 1'b1, 32'hFFFF_FFFF, 1'b1);
        drive(2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 2'b10, 1'b0, 2'd2, 5'd13, 1'b1, 32'h0000_007F, 1'b1);
        drive(2'b01, 32'h0, 32'h8001_7FFE, 32'h0, 2'b01, 1'b1, 2'd2, 5'd14, 1'b1, 32'h0000_7FFE, 1'b1);
        drive(2'b01, 32'h0, 32'h8001_7FFE, 32'h0, 2'b01, 1'b1, 2'd1, 5'd15, 1'b1, 32'hFFFF_8001, 1'b1);
        drive(2'b01, 32'h0, 32'h8001_7FFE, 32'h0, 2'b01, 1'b0, 2'd0, 5'd16, 1'b1, 32'h0000_8001, 1'b1);
        drive(2'b01, 32'h0, 32'h8001_7FFE, 32'h0, 2'b01, 1'b1, 2'd3, 5'd17, 1'b1, 32'h0000_7FFE, 1'b1);
        idle_cycles(3);
        #3;
        n_checks++;
        if (retire_cnt !== 4'd12) begin
            n_fails++; $display("FAIL load_cnt: got %0d, required 12", retire_cnt);
        end
    endtask

    task automatic test_stall();
        logic [CNT_W-1:0] c0;
        c0 = retire_cnt;
        drive(2'b10, 32'h1111_1111, 32'h0, 32'h0000_0108, 2'b00, 1'b0, 2'd0, 5'd31, 1'b1, 32'h0000_0108, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs();
            stall = 1'b1;
            #3;
            n_checks++;
            if (fwd_valid !== 1'b1 || fwd_rd !== 5'd31 || fwd_data !== 32'h0000_0108 ||
                rf_we !== 1'b0 || in_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL stall_hold: got fwd=%b rd=%0d data=%h we=%b ready=%b, required 1 31 00000108 0 0",
                         fwd_valid, fwd_rd, fwd_data, rf_we, in_ready);
            end
        end
        @(negedge clk);
        stall = 1'b0;
        idle_cycles(2);
        #3;
        n_checks++;
        if (retire_cnt !== c0 + 4'd1) begin
            n_fails++; $display("FAIL stall_cnt: got %0d, required %0d", retire_cnt, c0 + 4'd1);
        end
    endtask

    task automatic test_rd0_flush();
        logic [CNT_W-1:0] c0;
        c0 = retire_cnt;
        drive(2'b00, 32'hFFFF_0000, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0, 5'd0, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        idle_inputs();
        #3;
        n_checks++;
        if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin
            n_fails++; $display("FAIL rd0: got we=%b fwd=%b, required 0 0", rf_we, fwd_valid);
        end
        // flush + stall on a held instruction
        drive(2'b00, 32'h5555_AAAA, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0, 5'd5, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        idle_inputs();
        stall = 1'b1; flush = 1'b1;
        #3;
        n_checks++;
        if (rf_we !== 1'b0 || fwd_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fails++; $display("FAIL flush_stall_pre: got we=%b fwd=%b ready=%b, required 0 1 0", rf_we, fwd_valid, in_ready);
        end
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        #3;
        n_checks++;
        if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin
            n_fails++; $display("FAIL flush_stall_drop: got we=%b fwd=%b, required 0 0", rf_we, fwd_valid);
        end
        // flush alone squashes a newly presented instruction; in_ready stays high
        drive(2'b00, 32'h0BAD_0BAD, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0, 5'd6, 1'b1, 32'h0, 1'b0);
        flush = 1'b1;
        #3;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++; $display("FAIL flush_ready: got %b, required 1", in_ready);
        end
        @(negedge clk);
        idle_inputs();
        flush = 1'b0;
        #3;
        n_checks++;
        if (fwd_valid !== 1'b0 || rf_we !== 1'b0 || retire_cnt !== c0) begin
            n_fails++; $display("FAIL flush_only: got fwd=%b we=%b cnt=%0d, required 0 0 %0d", fwd_valid, rf_we, retire_cnt, c0);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(2'b00, 32'h7777_7777, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0, 5'd9, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        idle_inputs();
        stall = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (fwd_valid !== 1'b0 || rf_wdata !== '0 || retire_cnt !== '0) begin
            n_fails++; $display("FAIL reset_async: got fwd=%b data=%h cnt=%0d, required 0 0 0", fwd_valid, rf_wdata, retire_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        idle_cycles(2);
        #3;
        n_checks++;
        if (retire_cnt !== '0 || rf_we !== 1'b0) begin
            n_fails++; $display("FAIL reset_nowrite: got cnt=%0d we=%b, required 0 0", retire_cnt, rf_we);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] d;
        logic [RADDR-1:0] r;
        for (int i = 0; i < 16; i++) begin
            d = $urandom();
            r = RADDR'(i + 1);
            drive(2'b00, d, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0, r, 1'b1, d, 1'b1);
        end
        @(negedge clk);
        idle_inputs();
        #3;
        n_checks++;
        if (retire_cnt !== 4'd15) begin
            n_fails++; $display("FAIL b2b_cnt15: got %0d, required 15", retire_cnt);
        end
        @(negedge clk);
        #3;
        n_checks++;
        if (retire_cnt !== 4'd0) begin
            n_fails++; $display("FAIL b2b_wrap: got %0d, required 0", retire_cnt);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        test_reset();
        test_result();
        test_load_align();
        test_stall();
        test_rd0_flush();
        test_reset_mid_stall();
        test_back_to_back();
        idle_cycles(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++; $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
